// File: rtl/eth_rx_frame_check_pkg.sv
// Constants and state encoding shared by the receive frame checker and its CRC
// helper, so the transmit-side FCS generator can reuse the same values later.
package eth_rx_frame_check_pkg;

    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [47:0] ETH_BCAST       = 48'hFFFFFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2,
        ST_DONE = 2'd3
    } rx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational CRC-32 (reflected, LSB first) advance by one byte; no final inversion.
module eth_crc32_byte
    import eth_rx_frame_check_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] stage [0:8];

    assign stage[0] = crc_i;

    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        assign stage[gi+1] = {1'b0, stage[gi][31:1]}
                           ^ ((stage[gi][0] ^ data_i[gi]) ? ETH_CRC_POLY : 32'h0);
    end

    assign crc_o = stage[8];

endmodule

// File: rtl/eth_rx_frame_check.sv
// Receive-side frame checker: destination filtering, FCS residue and length checks,
// buffer writes, and a one-cycle frame_done carrying the latched frame status.
module eth_rx_frame_check
    import eth_rx_frame_check_pkg::*;
#(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    input  logic              rx_busy,
    input  logic [47:0]       mac_addr,
    input  logic              promisc,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              crc_err,
    output logic              len_err,
    output logic              addr_miss,
    output logic              ovf,
    output logic [10:0]       frame_len
);

    localparam logic [10:0] CNT_MAX   = 11'h7FF;
    localparam int unsigned BUF_BYTES = 1 << ADDR_W;

    rx_state_t   state_q, state_d;
    logic        busy_q;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d, crc_next;
    logic        bcast_q, bcast_d, ucast_q, ucast_d;
    logic        miss_q, miss_d, ovf_q, ovf_d;
    logic        wr_en_d;
    logic        busy_rise, busy_fall, buf_full, crc_bad, len_bad;
    logic [7:0]  mac_byte [0:7];

    // Byte 0 of the station address is the most significant octet on the wire.
    for (genvar gi = 0; gi < 8; gi++) begin : g_mac
        if (gi < 6) begin : g_hdr
            assign mac_byte[gi] = mac_addr[47-8*gi -: 8];
        end else begin : g_pad
            assign mac_byte[gi] = 8'h00;
        end
    end

    eth_crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (rx_data),
        .crc_o  (crc_next)
    );

    assign busy_rise = rx_busy & ~busy_q;
    assign busy_fall = busy_q & ~rx_busy;
    assign buf_full  = 32'(cnt_q) >= BUF_BYTES;
    assign crc_bad   = crc_q != ETH_CRC_RESIDUE;
    assign len_bad   = (32'(cnt_q) < MIN_LEN) | (32'(cnt_q) > MAX_LEN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        bcast_d = bcast_q;
        ucast_d = ucast_q;
        miss_d  = miss_q;
        ovf_d   = ovf_q;
        wr_en_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (busy_rise) begin
                    state_d = ST_RECV;
                    cnt_d   = '0;
                    crc_d   = ETH_CRC_INIT;
                    bcast_d = 1'b1;
                    ucast_d = 1'b1;
                    miss_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ST_RECV, ST_DROP: begin
                if (rx_rdy) begin
                    crc_d = crc_next;
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 11'd1;
                    if (buf_full) begin
                        ovf_d = 1'b1;
                    end else if (state_q == ST_RECV) begin
                        wr_en_d = 1'b1;
                    end
                    if (state_q == ST_RECV && cnt_q < 11'd6) begin
                        bcast_d = bcast_q & (rx_data == ETH_BCAST[7:0]);
                        ucast_d = ucast_q & (rx_data == mac_byte[cnt_q[2:0]]);
                        if (cnt_q == 11'd5 && !(bcast_d | ucast_d | promisc)) begin
                            miss_d  = 1'b1;
                            state_d = ST_DROP;
                        end
                    end
                end
                // End of frame wins over a same-cycle drop decision; the miss flag is kept.
                if (busy_fall) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            crc_q      <= ETH_CRC_INIT;
            bcast_q    <= 1'b1;
            ucast_q    <= 1'b1;
            miss_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            addr_miss  <= 1'b0;
            ovf        <= 1'b0;
            frame_len  <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= rx_busy;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            bcast_q    <= bcast_d;
            ucast_q    <= ucast_d;
            miss_q     <= miss_d;
            ovf_q      <= ovf_d;
            wr_en      <= wr_en_d;
            wr_addr    <= cnt_q[ADDR_W-1:0];
            wr_data    <= rx_data;
            frame_done <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                crc_err   <= crc_bad;
                len_err   <= len_bad;
                addr_miss <= miss_q;
                ovf       <= ovf_q;
                frame_ok  <= ~(crc_bad | len_bad | miss_q | ovf_q);
                frame_len <= cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_check.sv
// Bench for eth_rx_frame_check: a default instance and a small-buffer / short-minimum
// instance share one randomized byte stream and are checked against a frame-level model.
module tb_eth_rx_frame_check;

    localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
    localparam int          AW1  = 10;
    localparam int          MIN1 = 13;

    typedef struct {
        logic ok, crce, lene, miss, ovf;
        int   len, nwr, nbad;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        rx_busy = 1'b0;
    logic [47:0] mac_addr = MAC;
    logic        promisc = 1'b0;

    logic        wr_en_a [0:1];
    logic [7:0]  wr_data_a [0:1];
    logic        done_a [0:1], ok_a [0:1], crce_a [0:1], lene_a [0:1], miss_a [0:1], ovf_a [0:1];
    logic [10:0] len_a [0:1];
    logic [10:0] wr_addr0;
    logic [9:0]  wr_addr1;

    logic [7:0]  frames [0:1][0:2047];
    int          flen [0:1];
    int          send_slot = 0;
    int          frame_no = 0;
    int          checked_no = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    int          mwr [0:1];
    int          mbad [0:1];
    int          mslot [0:1];
    res_t        mon_r;
    res_t        resq0[$], resq1[$], expq0[$], expq1[$];

    always #10 clk = ~clk;

    eth_rx_frame_check u_dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_busy(rx_busy),
        .mac_addr(mac_addr), .promisc(promisc),
        .wr_en(wr_en_a[0]), .wr_addr(wr_addr0), .wr_data(wr_data_a[0]),
        .frame_done(done_a[0]), .frame_ok(ok_a[0]), .crc_err(crce_a[0]), .len_err(lene_a[0]),
        .addr_miss(miss_a[0]), .ovf(ovf_a[0]), .frame_len(len_a[0])
    );

    eth_rx_frame_check #(.ADDR_W(AW1), .MIN_LEN(MIN1), .MAX_LEN(1518)) u_dut_small (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_busy(rx_busy),
        .mac_addr(mac_addr), .promisc(promisc),
        .wr_en(wr_en_a[1]), .wr_addr(wr_addr1), .wr_data(wr_data_a[1]),
        .frame_done(done_a[1]), .frame_ok(ok_a[1]), .crc_err(crce_a[1]), .len_err(lene_a[1]),
        .addr_miss(miss_a[1]), .ovf(ovf_a[1]), .frame_len(len_a[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    // Standard Ethernet FCS value of the first n bytes of a stored frame.
    function automatic logic [31:0] fcs_of(input int s, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, frames[s][i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic res_t model(input int s, input int aw, input int min_len);
        res_t        r;
        int          n = flen[s];
        logic [47:0] dest = '0;
        logic [31:0] tail;
        logic        hit;
        for (int i = 0; i < 6 && i < n; i++) dest = {dest[39:0], frames[s][i]};
        tail   = {frames[s][n-1], frames[s][n-2], frames[s][n-3], frames[s][n-4]};
        hit    = (n < 6) || (dest == MAC) || (dest == 48'hFFFFFFFFFFFF) || promisc;
        r.miss = !hit;
        r.crce = fcs_of(s, n - 4) != tail;
        r.lene = (n < min_len) || (n > 1518);
        r.ovf  = n > (1 << aw);
        r.ok   = !(r.crce | r.lene | r.miss | r.ovf);
        r.len  = (n > 2047) ? 2047 : n;
        r.nwr  = r.miss ? 6 : (r.ovf ? (1 << aw) : n);
        r.nbad = 0;
        return r;
    endfunction

    // Collects each instance's writes per frame; writes must be in order 0,1,2.. with frame data.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mwr[k]  = 0;
                mbad[k] = 0;
            end else begin
                if (wr_en_a[k]) begin
                    if (int'((k == 0) ? wr_addr0 : {1'b0, wr_addr1}) != mwr[k] ||
                        wr_data_a[k] != frames[mslot[k]][mwr[k]]) mbad[k]++;
                    mwr[k]++;
                end
                if (done_a[k]) begin
                    mon_r.ok   = ok_a[k];
                    mon_r.crce = crce_a[k];
                    mon_r.lene = lene_a[k];
                    mon_r.miss = miss_a[k];
                    mon_r.ovf  = ovf_a[k];
                    mon_r.len  = int'(len_a[k]);
                    mon_r.nwr  = mwr[k];
                    mon_r.nbad = mbad[k];
                    if (k == 0) resq0.push_back(mon_r);
                    else        resq1.push_back(mon_r);
                    mwr[k]   = 0;
                    mbad[k]  = 0;
                    mslot[k] = mslot[k] ^ 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build(input int n, input int kind, input bit good, input bit flip);
        int          s = send_slot;
        logic [47:0] dest;
        logic [31:0] c;
        int          p;
        case (kind)
            0:       dest = MAC;
            1:       dest = 48'hFFFF_FFFF_FFFF;
            2:       dest = 48'h02_00_00_00_00_02;
            default: dest = {16'($urandom), $urandom};
        endcase
        for (int i = 0; i < n; i++) frames[s][i] = (i < 6) ? dest[47-8*i -: 8] : 8'($urandom);
        if (good) begin
            c = fcs_of(s, n - 4);
            for (int j = 0; j < 4; j++) frames[s][n-4+j] = c[8*j +: 8];
        end
        if (flip && n > 10) begin
            p = $urandom_range(6, n - 5);
            frames[s][p] ^= 8'(1 << $urandom_range(0, 7));
        end
        flen[s] = n;
    endtask

    task automatic xmit(input bit tail_fall, input bit b2b, input string what);
        int s = send_slot;
        int n = flen[s];
        expq0.push_back(model(s, 11, 64));
        expq1.push_back(model(s, AW1, MIN1));
        $display("[TB] frame %0d: %s, %0d bytes, promisc=%0d, tail_fall=%0d, b2b=%0d",
                 frame_no, what, n, promisc, tail_fall, b2b);
        frame_no++;
        rx_busy = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            rx_data = frames[s][i];
            rx_rdy  = 1'b1;
            if (i == n - 1 && tail_fall) rx_busy = 1'b0;
            tick();
            rx_rdy = 1'b0;
            if (i < n - 1) repeat ($urandom_range(0, 2)) tick();
        end
        rx_busy = 1'b0;
        tick();
        send_slot ^= 1;
        if (!b2b) repeat (3) tick();
    endtask

    task automatic compare(input int k, input res_t e, input res_t r);
        string p = $sformatf("frame%0d_dut%0d_", checked_no, k);
        check_eq({p, "frame_ok"},  r.ok,   e.ok);
        check_eq({p, "crc_err"},   r.crce, e.crce);
        check_eq({p, "len_err"},   r.lene, e.lene);
        check_eq({p, "addr_miss"}, r.miss, e.miss);
        check_eq({p, "ovf"},       r.ovf,  e.ovf);
        check_eq({p, "frame_len"}, r.len,  e.len);
        check_eq({p, "wr_count"},  r.nwr,  e.nwr);
        check_eq({p, "wr_order_data_errors"}, r.nbad, e.nbad);
    endtask

    task automatic collect();
        int   waited = 0;
        res_t e, r;
        while ((resq0.size() < expq0.size() || resq1.size() < expq1.size()) && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50)
            check_eq("frame_done_timeout", resq0.size() + resq1.size(), expq0.size() + expq1.size());
        while (expq0.size() > 0 && resq0.size() > 0) begin
            e = expq0.pop_front();
            r = resq0.pop_front();
            compare(0, e, r);
            checked_no++;
        end
        while (expq1.size() > 0 && resq1.size() > 0) begin
            e = expq1.pop_front();
            r = resq1.pop_front();
            compare(1, e, r);
        end
        check_eq("unmatched_frame_done", resq0.size() + resq1.size() + expq0.size() + expq1.size(), 0);
        resq0.delete(); resq1.delete(); expq0.delete(); expq1.delete();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [103:0] golden;
        int           s;
        mwr   = '{0, 0};
        mbad  = '{0, 0};
        mslot = '{0, 0};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("reset_wr_en",      wr_en_a[0], 1'b0);
        check_eq("reset_frame_done", done_a[0],  1'b0);
        check_eq("reset_frame_ok",   ok_a[0],    1'b0);
        check_eq("reset_frame_len",  len_a[0],   11'd0);
        check_eq("reset_crc_err",    crce_a[0],  1'b0);
        check_eq("reset_small_ok",   ok_a[1],    1'b0);

        // "123456789" followed by its FCS bytes; small instance accepts it at 13 bytes.
        promisc = 1'b1;
        build(13, 3, 1'b0, 1'b0);
        golden = {"123456789", 32'h2639F4CB};
        for (int i = 0; i < 13; i++) frames[send_slot][i] = golden[103-8*i -: 8];
        xmit(1'b0, 1'b0, "golden check value");
        collect();

        promisc = 1'b0;
        build(64, 0, 1'b1, 1'b0);    xmit(1'b0, 1'b0, "unicast good");         collect();
        build(64, 0, 1'b1, 1'b1);    xmit(1'b0, 1'b0, "unicast bit flip");     collect();
        build(64, 2, 1'b1, 1'b0);    xmit(1'b0, 1'b0, "unicast other station"); collect();
        build(64, 1, 1'b1, 1'b0);    xmit(1'b1, 1'b0, "broadcast, rdy on fall"); collect();
        build(63, 0, 1'b1, 1'b0);    xmit(1'b0, 1'b0, "63 bytes");             collect();
        build(1518, 0, 1'b1, 1'b0);  xmit(1'b0, 1'b0, "1518 bytes");           collect();
        build(1519, 0, 1'b1, 1'b0);  xmit(1'b0, 1'b0, "1519 bytes");           collect();
        build(5, 0, 1'b1, 1'b0);     xmit(1'b0, 1'b0, "5 bytes");              collect();

        build(64, 0, 1'b1, 1'b0);    xmit(1'b0, 1'b1, "back-to-back first");
        build(70, 1, 1'b1, 1'b0);    xmit(1'b0, 1'b0, "back-to-back second");
        collect();

        // Abort a frame with reset at byte 20 while rx_busy stays high.
        build(64, 0, 1'b1, 1'b0);    xmit(1'b0, 1'b0, "good frame before reset"); collect();
        build(64, 0, 1'b1, 1'b0);
        s = send_slot;
        $display("[TB] frame %0d: reset at byte 20, 64 bytes", frame_no);
        frame_no++;
        rx_busy = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            rx_data = frames[s][i]; rx_rdy = 1'b1; tick(); rx_rdy = 1'b0; tick();
        end
        rst = 1'b1;
        #2;
        check_eq("rst_mid_frame_ok_cleared",  ok_a[0],  1'b0);
        check_eq("rst_mid_frame_len_cleared", len_a[0], 11'd0);
        check_eq("rst_mid_frame_small_ok",    ok_a[1],  1'b0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 20; i < 30; i++) begin
            rx_data = frames[s][i]; rx_rdy = 1'b1; tick(); rx_rdy = 1'b0; tick();
        end
        rx_busy = 1'b0;
        repeat (6) tick();
        check_eq("aborted_frame_done", resq0.size() + resq1.size(), 0);
        check_eq("aborted_writes_dut0", mwr[0], 0);
        check_eq("aborted_writes_dut1", mwr[1], 0);
        build(64, 0, 1'b1, 1'b0);    xmit(1'b0, 1'b0, "clean frame after reset"); collect();

        for (int it = 0; it < 12; it++) begin
            for (int j = 0; j < 2; j++) begin
                int  n    = ($urandom_range(0, 2) == 0) ? $urandom_range(60, 70) : $urandom_range(5, 130);
                bit  good = $urandom_range(0, 3) != 0;
                bit  flip = good && ($urandom_range(0, 3) == 0);
                promisc = ($urandom_range(0, 4) == 0);
                build(n, $urandom_range(0, 3), good, flip);
                xmit(1'($urandom_range(0, 1)), (j == 0) && ($urandom_range(0, 1) == 1), "random");
            end
            collect();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
